// File: rtl/slice_scheduler.sv
// Rotation-locked slice scheduler: measures the hall period, cuts each rotation
// into NB_SLICES equal slices and paces the column driver with SOF/start_config.
//
// Ports:
//   clk, nrst          clock, asynchronous active-low reset
//   hall               raw hall-sensor level, one rising edge per rotation
//   config_req         1-cycle request to reconfigure, word on config_in[47:0]
//   EOC, end_config    end-of-column / end-of-configuration from the driver
//   SOF, start_config  1-cycle start-of-slice / start-of-configuration pulses
//   config_data[47:0]  last requested configuration word
//   slice_idx[7:0]     slice currently displayed
//   rotation_valid     high while in RUN
//   overrun            sticky: a slice boundary arrived while the driver was busy
module slice_scheduler #(
    parameter int NB_SLICES         = 128,
    parameter int COLUMNS_PER_SLICE = 8,
    parameter int MIN_PERIOD        = 4096,
    parameter int MAX_PERIOD        = 2**26
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        hall,
    input  logic        config_req,
    input  logic [47:0] config_in,
    input  logic        EOC,
    input  logic        end_config,
    output logic        SOF,
    output logic        start_config,
    output logic [47:0] config_data,
    output logic [7:0]  slice_idx,
    output logic        rotation_valid,
    output logic        overrun
);

    localparam int SHIFT = $clog2(NB_SLICES);
    localparam int EW    = $clog2(COLUMNS_PER_SLICE + 1);
    localparam logic [31:0]   MINP     = 32'(MIN_PERIOD);
    localparam logic [31:0]   MAXP     = 32'(MAX_PERIOD);
    localparam logic [7:0]    IDX_MASK = 8'(NB_SLICES - 1);
    localparam logic [EW-1:0] EOC_LAST = EW'(COLUMNS_PER_SLICE - 1);

    typedef enum logic [1:0] {IDLE, SYNC, RUN, CONFIG} state_t;

    state_t        state;
    logic          hall_meta, hall_sync, hall_prev;
    logic [31:0]   period_cnt, period_reg, slice_timer;
    logic          had_edge, period_valid;
    logic          busy, cfg_pending;
    logic [EW-1:0] eoc_cnt;

    logic          hall_edge, timeout, edge_ok, edge_restart, go_edge;
    logic          ticking, hall_tick, timer_tick, sync_go, slice_tick;
    logic [31:0]   meas, slice_len;

    assign hall_edge    = hall_sync & ~hall_prev;
    assign timeout      = (period_cnt == MAXP);
    assign meas         = period_cnt + 32'd1;
    assign edge_ok      = hall_edge && (meas >= MINP) && (meas <= MAXP);
    // Once timed out the counter is saturated, so no edge could ever measure
    // as valid again; the next edge restarts measurement instead.
    assign edge_restart = hall_edge && timeout;
    assign go_edge      = edge_ok | edge_restart;

    assign slice_len  = period_reg >> SHIFT;
    assign ticking    = ((state == RUN) || (state == CONFIG))
                        && period_valid && !timeout;
    assign hall_tick  = ticking && edge_ok;
    assign timer_tick = ticking && (slice_timer == slice_len - 32'd1);
    // The edge that makes the period meaningful also opens slice 0.
    assign sync_go    = (state == SYNC) && edge_ok;
    assign slice_tick = hall_tick | timer_tick | sync_go;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            hall_meta <= 1'b0;
            hall_sync <= 1'b0;
            hall_prev <= 1'b0;
        end else begin
            hall_meta <= hall;
            hall_sync <= hall_meta;
            hall_prev <= hall_sync;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            period_cnt   <= '0;
            period_reg   <= '0;
            had_edge     <= 1'b0;
            period_valid <= 1'b0;
        end else begin
            if (go_edge)
                period_cnt <= '0;
            else if (!timeout)
                period_cnt <= period_cnt + 32'd1;
            if (edge_ok)
                period_reg <= meas;
            if (go_edge)
                had_edge <= 1'b1;
            else if (timeout)
                had_edge <= 1'b0;
            // Only an edge-to-edge measurement counts as a real period.
            if (edge_ok && had_edge)
                period_valid <= 1'b1;
            else if (timeout)
                period_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            slice_timer <= '0;
            slice_idx   <= '0;
        end else if (timeout || hall_tick || sync_go) begin
            slice_timer <= '0;
            slice_idx   <= '0;
        end else if (timer_tick) begin
            slice_timer <= '0;
            slice_idx   <= (slice_idx + 8'd1) & IDX_MASK;
        end else if (ticking) begin
            slice_timer <= slice_timer + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state          <= IDLE;
            SOF            <= 1'b0;
            start_config   <= 1'b0;
            rotation_valid <= 1'b0;
            overrun        <= 1'b0;
            busy           <= 1'b0;
            eoc_cnt        <= '0;
            cfg_pending    <= 1'b0;
            config_data    <= '0;
        end else begin
            SOF          <= 1'b0;
            start_config <= 1'b0;
            if (config_req) begin
                config_data <= config_in;
                cfg_pending <= 1'b1;
            end
            if (busy && EOC) begin
                if (eoc_cnt == EOC_LAST) begin
                    busy    <= 1'b0;
                    eoc_cnt <= '0;
                end else begin
                    eoc_cnt <= eoc_cnt + EW'(1);
                end
            end
            unique case (state)
                IDLE: begin
                    if (cfg_pending && !busy) begin
                        start_config <= 1'b1;
                        state        <= CONFIG;
                        if (!config_req) cfg_pending <= 1'b0;
                    end else if (go_edge) begin
                        state <= SYNC;
                    end
                end
                SYNC: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (cfg_pending && !busy) begin
                        start_config <= 1'b1;
                        state        <= CONFIG;
                        if (!config_req) cfg_pending <= 1'b0;
                    end else if (edge_ok) begin
                        state          <= RUN;
                        rotation_valid <= 1'b1;
                        if (busy) begin
                            overrun <= 1'b1;
                        end else begin
                            SOF  <= 1'b1;
                            busy <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (timeout) begin
                        state          <= IDLE;
                        rotation_valid <= 1'b0;
                    end else if (slice_tick) begin
                        if (busy) begin
                            overrun <= 1'b1;
                        end else if (cfg_pending) begin
                            start_config   <= 1'b1;
                            state          <= CONFIG;
                            rotation_valid <= 1'b0;
                            if (!config_req) cfg_pending <= 1'b0;
                        end else begin
                            SOF  <= 1'b1;
                            busy <= 1'b1;
                        end
                    end
                end
                CONFIG: begin
                    if (end_config) begin
                        if (period_valid && !timeout) begin
                            state          <= RUN;
                            rotation_valid <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_slice_scheduler.sv
// Randomized scoreboard bench for slice_scheduler (4 slices, 4000-cycle rotation).
// Expected pulses come from slice-boundary arithmetic, not from the RTL.
module tb_slice_scheduler;

    logic        clk;
    logic        nrst;
    logic        hall;
    logic        config_req;
    logic [47:0] config_in;
    logic        EOC;
    logic        end_config;
    logic        SOF;
    logic        start_config;
    logic [47:0] config_data;
    logic [7:0]  slice_idx;
    logic        rotation_valid;
    logic        overrun;

    slice_scheduler #(
        .NB_SLICES(4),
        .COLUMNS_PER_SLICE(8),
        .MIN_PERIOD(16),
        .MAX_PERIOD(20000)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .hall(hall),
        .config_req(config_req),
        .config_in(config_in),
        .EOC(EOC),
        .end_config(end_config),
        .SOF(SOF),
        .start_config(start_config),
        .config_data(config_data),
        .slice_idx(slice_idx),
        .rotation_valid(rotation_valid),
        .overrun(overrun)
    );

    typedef struct {
        bit          is_cfg;
        int          cyc;
        logic [47:0] val;
    } exp_t;

    exp_t        q[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          withhold_at = -1;
    int          R, N, E0, E1, E_last, cfg_n, wh_n;
    logic [47:0] cfg_word;

    localparam int PERIOD = 4000;
    localparam int SLICE  = 1000;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int now_cyc();
        return int'(($time - 5) / 10);
    endfunction

    function automatic int bnd(input int n);
        return E1 + 3 + n * SLICE;
    endfunction

    task automatic wait_cyc(input int c);
        do @(negedge clk); while (now_cyc() < c);
    endtask

    task automatic check(input string name, input longint act,
                         input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h",
                     name, now_cyc(), act, exp);
        end
    endtask

    // Scoreboard monitor: every SOF/start_config must match the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (nrst && (SOF || start_config)) begin
                check("sof_cfg_exclusive", SOF & start_config, 0);
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse at cycle %0d: sof=%0b cfg=%0b",
                             now_cyc(), SOF, start_config);
                end else begin
                    e = q.pop_front();
                    check("pulse_kind", start_config, e.is_cfg);
                    check("pulse_cycle", now_cyc(), e.cyc);
                    if (e.is_cfg)
                        check("config_data", config_data, e.val);
                    else
                        check("slice_idx", slice_idx, e.val);
                end
            end
        end
    end

    task automatic send_eocs();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(1, 15)) @(negedge clk);
            EOC = 1'b1;
            @(negedge clk);
            EOC = 1'b0;
        end
    endtask

    // Driver model: answers each SOF with 8 EOCs, except one late slice.
    initial begin
        EOC = 1'b0;
        forever begin
            @(negedge clk);
            if (nrst && SOF) begin
                if (now_cyc() == withhold_at)
                    repeat (SLICE + 10) @(negedge clk);
                send_eocs();
            end
        end
    end

    initial begin
        repeat (90000) @(posedge clk);
        $display("FAIL watchdog: run exceeded cycle budget");
        $fatal(1, "watchdog");
    end

    task automatic pulse_hall(input int e);
        wait_cyc(e);
        hall = 1'b1;
        wait_cyc(e + 5);
        hall = 1'b0;
    endtask

    task automatic drive_hall();
        int e;
        for (int r = -1; r < R; r++) begin
            e = (r < 0) ? E0 : E1 + r * PERIOD;
            pulse_hall(e);
            // A second edge 10 cycles later is shorter than MIN_PERIOD.
            if ($urandom_range(0, 1) == 1)
                pulse_hall(e + 10);
        end
    endtask

    task automatic model();
        exp_t e;
        for (int n = 0; n < N; n++) begin
            wait_cyc(bnd(n) - 5);
            if (n != wh_n + 1) begin
                e.cyc = bnd(n);
                if (n == cfg_n) begin
                    e.is_cfg = 1'b1;
                    e.val    = cfg_word;
                end else begin
                    e.is_cfg = 1'b0;
                    e.val    = 48'(n % 4);
                end
                q.push_back(e);
            end
        end
    endtask

    task automatic drive_cfg();
        int d, c;
        d = $urandom_range(100, 400);
        c = bnd(cfg_n) - d;
        wait_cyc(c);
        config_req = 1'b1;
        config_in  = 48'({$urandom(), $urandom()});
        wait_cyc(c + 1);
        config_req = 1'b0;
        config_in  = 48'({$urandom(), $urandom()});
        wait_cyc(c + 30);
        config_req = 1'b1;
        config_in  = cfg_word;
        wait_cyc(c + 31);
        config_req = 1'b0;
        wait_cyc(bnd(cfg_n) + $urandom_range(20, 500));
        end_config = 1'b1;
        wait_cyc(now_cyc() + 1);
        end_config = 1'b0;
    endtask

    task automatic probes();
        wait_cyc(E1 + 2);
        check("rv_before_run", rotation_valid, 0);
        wait_cyc(E1 + 3);
        check("rv_in_run", rotation_valid, 1);
        wait_cyc(bnd(wh_n + 1) - 1);
        check("overrun_clear", overrun, 0);
        wait_cyc(bnd(wh_n + 1));
        check("overrun_set", overrun, 1);
        wait_cyc(E_last + 20003);
        check("rv_before_timeout", rotation_valid, 1);
        check("overrun_sticky", overrun, 1);
        wait_cyc(E_last + 20004);
        check("rv_after_timeout", rotation_valid, 0);
        check("idx_after_timeout", slice_idx, 0);
    endtask

    task automatic issue_cfg_now(input logic [47:0] w);
        exp_t e;
        int   k;
        k = now_cyc();
        e.is_cfg = 1'b1;
        e.cyc    = k + 2;
        e.val    = w;
        q.push_back(e);
        config_req = 1'b1;
        config_in  = w;
        wait_cyc(k + 1);
        config_req = 1'b0;
    endtask

    initial begin
        logic [47:0] w;
        int          k;
        nrst       = 1'b0;
        hall       = 1'b0;
        config_req = 1'b0;
        config_in  = '0;
        end_config = 1'b0;

        R        = $urandom_range(3, 5);
        E0       = 40;
        E1       = E0 + PERIOD;
        E_last   = E1 + (R - 1) * PERIOD;
        N        = (R - 1) * 4 + 21;
        cfg_n    = $urandom_range(1, 6);
        wh_n     = $urandom_range(8, N - 4);
        cfg_word = 48'({$urandom(), $urandom()}) | 48'h1;
        withhold_at = bnd(wh_n);

        wait_cyc(3);
        check("rst_sof", SOF, 0);
        check("rst_start_config", start_config, 0);
        check("rst_config_data", config_data, 0);
        check("rst_slice_idx", slice_idx, 0);
        check("rst_rotation_valid", rotation_valid, 0);
        check("rst_overrun", overrun, 0);
        wait_cyc(5);
        nrst = 1'b1;

        fork
            drive_hall();
            model();
            drive_cfg();
            probes();
        join

        // Idle configuration: issued without any slice tick.
        wait_cyc(E_last + 20500);
        w = 48'({$urandom(), $urandom()}) | 48'h1;
        issue_cfg_now(w);
        k = now_cyc();
        wait_cyc(k + 10);
        end_config = 1'b1;
        wait_cyc(k + 11);
        end_config = 1'b0;
        wait_cyc(k + 30);
        check("idle_cfg_rv", rotation_valid, 0);

        // Reset while waiting for end_config.
        wait_cyc(k + 100);
        w = 48'({$urandom(), $urandom()}) | 48'h1;
        issue_cfg_now(w);
        k = now_cyc();
        wait_cyc(k + 20);
        nrst = 1'b0;
        wait_cyc(k + 21);
        check("cfg_rst_sof", SOF, 0);
        check("cfg_rst_start_config", start_config, 0);
        check("cfg_rst_config_data", config_data, 0);
        check("cfg_rst_slice_idx", slice_idx, 0);
        check("cfg_rst_rv", rotation_valid, 0);
        check("cfg_rst_overrun", overrun, 0);
        wait_cyc(k + 23);
        nrst = 1'b1;
        wait_cyc(k + 400);
        check("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
